// File: rtl/svc_debounce_pkg.sv
// svc_debounce_pkg: per-channel state encoding shared by the debouncer files
package svc_debounce_pkg;

    localparam logic ST_STABLE   = 1'b0;
    localparam logic ST_COUNTING = 1'b1;

endpackage

// File: rtl/svc_debounce_chan.sv
// svc_debounce_chan: one debounced channel, accepts a new level after STABLE_CYCLES differing samples
module svc_debounce_chan
    import svc_debounce_pkg::*;
#(
    parameter int   STABLE_CYCLES = 16,
    parameter logic RST_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic          r_q;
    logic          r_rise;
    logic          r_fall;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_diff;
    logic          w_accept;
    logic          w_state;

    always_comb begin
        w_diff    = d ^ r_q;
        w_accept  = w_diff && (r_cnt == LAST);
        // any sample matching q, or an accepted change, restarts the window
        w_cnt_nxt = (!w_diff || w_accept) ? '0 : r_cnt + CW'(1);
        w_state   = (r_cnt != '0) ? ST_COUNTING : ST_STABLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_q    <= RST_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_q    <= w_accept ? d : r_q;
            r_rise <= w_accept & d;
            r_fall <= w_accept & ~d;
        end
    end

    assign q    = r_q;
    assign rise = r_rise;
    assign fall = r_fall;
    assign busy = (w_state == ST_COUNTING);

endmodule

// File: rtl/svc_debounce.sv
// svc_debounce: WIDTH independent debounced channels with edge pulses and busy flags
module svc_debounce #(
    parameter int             WIDTH         = 1,
    parameter int             STABLE_CYCLES = 16,
    parameter logic [WIDTH-1:0] RST_VAL     = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] busy
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        svc_debounce_chan #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .RST_VAL       (RST_VAL[i])
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (d[i]),
            .q     (q[i]),
            .rise  (rise[i]),
            .fall  (fall[i]),
            .busy  (busy[i])
        );
    end

endmodule

// File: tb/tb_svc_debounce.sv
// tb_svc_debounce: directed vectors for a 2-channel debouncer with STABLE_CYCLES=4
module tb_svc_debounce;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] d = 2'b00;
    logic [1:0] q, rise, fall, busy;
    int         n_vec = 0;
    int         n_bad = 0;

    svc_debounce #(
        .WIDTH         (2),
        .STABLE_CYCLES (4),
        .RST_VAL       (2'b00)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (d),
        .q     (q),
        .rise  (rise),
        .fall  (fall),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [1:0] eq, input logic [1:0] er,
                             input logic [1:0] ef, input logic [1:0] eb);
        check({tag, ".q"},    {6'b0, q},    {6'b0, eq});
        check({tag, ".rise"}, {6'b0, rise}, {6'b0, er});
        check({tag, ".fall"}, {6'b0, fall}, {6'b0, ef});
        check({tag, ".busy"}, {6'b0, busy}, {6'b0, eb});
    endtask

    initial begin
        #12;
        check_all("reset", 2'b00, 2'b00, 2'b00, 2'b00);
        rst_n = 1'b1;
        step();
        check_all("idle", 2'b00, 2'b00, 2'b00, 2'b00);

        // bit0 clean step, bit1 high for 3 edges then low on the 4th
        d = 2'b11;
        for (int k = 1; k <= 3; k++) begin
            step();
            check_all($sformatf("step_e%0d", k), 2'b00, 2'b00, 2'b00, 2'b11);
        end
        d = 2'b01;
        step();
        check_all("step_e4", 2'b01, 2'b01, 2'b00, 2'b00);
        step();
        check_all("step_e5", 2'b01, 2'b00, 2'b00, 2'b00);

        d = 2'b00;
        for (int k = 1; k <= 3; k++) begin
            step();
            check_all($sformatf("fall_e%0d", k), 2'b01, 2'b00, 2'b00, 2'b01);
        end
        step();
        check_all("fall_e4", 2'b00, 2'b00, 2'b01, 2'b00);
        step();
        check_all("fall_e5", 2'b00, 2'b00, 2'b00, 2'b00);

        d = 2'b01;
        repeat (3) step();
        check_all("glitch_e3", 2'b00, 2'b00, 2'b00, 2'b01);
        d = 2'b00;
        step();
        check_all("glitch_e4", 2'b00, 2'b00, 2'b00, 2'b00);
        d = 2'b01;
        step();
        check_all("glitch_restart", 2'b00, 2'b00, 2'b00, 2'b01);
        d = 2'b00;
        step();

        d = 2'b01;
        repeat (2) step();
        check_all("rst_mid_pre", 2'b00, 2'b00, 2'b00, 2'b01);
        #2 rst_n = 1'b0;
        #1;
        check_all("rst_mid_async", 2'b00, 2'b00, 2'b00, 2'b00);
        step();
        #1 rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            check_all($sformatf("rst_rel_e%0d", k), 2'b00, 2'b00, 2'b00, 2'b01);
        end
        step();
        check_all("rst_rel_e4", 2'b01, 2'b01, 2'b00, 2'b00);

        #1 rst_n = 1'b0;
        #1;
        check_all("rst_from_q1", 2'b00, 2'b00, 2'b00, 2'b00);
        #2 rst_n = 1'b1;
        d = 2'b10;
        repeat (3) step();
        check_all("bit1_e3", 2'b00, 2'b00, 2'b00, 2'b10);
        step();
        check_all("bit1_e4", 2'b10, 2'b10, 2'b00, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
